// File: rtl/text_ram_arbiter.sv
// ---------------------------------------------------------------------------
// text_ram_arbiter
//   Shares one single-port synchronous text RAM between the display scan-out
//   fetch path and a host port. The display has absolute priority. The host
//   is served from a one-entry holding register in cycles the display leaves
//   idle. All RAM control outputs are registered.
//
//   Optional feature macro: TEXT_ARB_HOST_READ_EN
//     defined   - host reads are supported (host_we_i selects read/write)
//     undefined - every host transaction is a write, host read outputs are 0
//
// Ports
//   clk_i, rst_ni          pixel clock, asynchronous active-low reset
//   disp_req_i/addr_i      display fetch request, one per cycle
//   disp_rvalid_o/rdata_o  display read data, 3 cycles after the request
//   host_valid_i/ready_o   host handshake (transfer on valid && ready)
//   host_we_i/addr_i/wdata_i  host transaction fields
//   host_rvalid_o/rdata_o  host read data, 3 cycles after issue
//   host_err_o             pulse when an out-of-range host transaction issues
//   mem_en_o/we_o/addr_o/wdata_o  registered RAM controls
//   mem_rdata_i            RAM read data, valid one cycle after a read enable
// ---------------------------------------------------------------------------
module text_ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2400
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_rvalid_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    // Slot owner/kind tag travelling alongside each RAM access. oor marks a
    // slot that was consumed without touching the RAM; its read data is 0.
    typedef struct packed {
        logic disp;
`ifdef TEXT_ARB_HOST_READ_EN
        logic host;
`endif
        logic oor;
    } tag_t;

    // Host holding register
    logic              hold_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_wdata_q;
    logic              hold_wr;

    // RAM control registers
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    tag_t              tag_d;
    tag_t [1:0]        tag_q;   // [0]: RAM command cycle, [1]: RAM data cycle

    logic              err_d, host_err_q;
    logic              disp_rvalid_q;
    logic [DATA_W-1:0] disp_rdata_q;

    logic accept, host_issue, disp_in_range, host_in_range;

    assign accept        = host_valid_i & ~hold_q;
    assign host_issue    = hold_q & ~disp_req_i;
    assign disp_in_range = {1'b0, disp_addr_i} < LIMIT;
    assign host_in_range = {1'b0, hold_addr_q} < LIMIT;

`ifdef TEXT_ARB_HOST_READ_EN
    logic hold_we_q;
    assign hold_wr = hold_we_q;
`else
    // Host reads are compiled out: host_we_i has no effect.
    logic unused_we;
    assign unused_we = host_we_i;
    assign hold_wr   = 1'b1;
`endif

    // Slot arbitration: display first, then the held host transaction.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_d       = '0;
        err_d       = 1'b0;
        if (disp_req_i) begin
            tag_d.disp = 1'b1;
            tag_d.oor  = ~disp_in_range;
            if (disp_in_range) begin
                mem_en_d   = 1'b1;
                mem_addr_d = disp_addr_i;
            end
        end else if (hold_q) begin
`ifdef TEXT_ARB_HOST_READ_EN
            tag_d.host = ~hold_wr;
`endif
            tag_d.oor  = ~host_in_range;
            if (host_in_range) begin
                mem_en_d    = 1'b1;
                mem_we_d    = hold_wr;
                mem_addr_d  = hold_addr_q;
                mem_wdata_d = hold_wdata_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q        <= 1'b0;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tag_q         <= '0;
            host_err_q    <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
        end else begin
            // accept and issue are mutually exclusive (accept needs !hold_q)
            if (accept) begin
                hold_q       <= 1'b1;
                hold_addr_q  <= host_addr_i;
                hold_wdata_q <= host_wdata_i;
            end else if (host_issue) begin
                hold_q <= 1'b0;
            end
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            tag_q         <= {tag_q[0], tag_d};
            host_err_q    <= err_d;
            disp_rvalid_q <= tag_q[1].disp;
            if (tag_q[1].disp)
                disp_rdata_q <= tag_q[1].oor ? '0 : mem_rdata_i;
        end
    end

`ifdef TEXT_ARB_HOST_READ_EN
    logic              host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_we_q     <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            if (accept)
                hold_we_q <= host_we_i;
            host_rvalid_q <= tag_q[1].host;
            if (tag_q[1].host)
                host_rdata_q <= tag_q[1].oor ? '0 : mem_rdata_i;
        end
    end

    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rdata_q;
`else
    assign host_rvalid_o = 1'b0;
    assign host_rdata_o  = '0;
`endif

    assign host_ready_o  = ~hold_q;
    assign host_err_o    = host_err_q;
    assign disp_rvalid_o = disp_rvalid_q;
    assign disp_rdata_o  = disp_rdata_q;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: behavioural single-port RAM, read-data
// scoreboards for both requesters, a vector table for display fetches and
// hand-written sequences for contention, out-of-range and reset cases.
module tb_text_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          host_err;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    text_ram_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .disp_req_i(disp_req), .disp_addr_i(disp_addr),
        .disp_rvalid_o(disp_rvalid), .disp_rdata_o(disp_rdata),
        .host_valid_i(host_valid), .host_ready_o(host_ready),
        .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM model
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end

    function automatic logic [7:0] init_val(input int a);
        logic [11:0] av;
        av = 12'(a);
        if (a < 8)       return 8'(8'h41 + a);
        else if (a == 100) return 8'h33;
        else             return av[7:0] ^ 8'hA5;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards: due = cycle count seen at the negedge where rvalid must be high
    typedef struct { int due; logic [7:0] data; } exp_t;
    exp_t dq[$];
    exp_t hq[$];

    always @(negedge clk) begin
        exp_t e;
        if (disp_rvalid) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL disp_unexpected: got rvalid data %0h expected none (cycle %0d)", disp_rdata, cyc);
            end else begin
                e = dq.pop_front();
                chk("disp_latency", cyc, e.due);
                chk("disp_data", disp_rdata, e.data);
            end
        end
        if (dq.size() != 0 && dq[0].due < cyc) begin
            e = dq.pop_front();
            checks++; errors++;
            $display("FAIL disp_missing: got no rvalid expected data %0h at cycle %0d", e.data, e.due);
        end
        if (host_rvalid) begin
            if (hq.size() == 0) begin
                checks++; errors++;
                $display("FAIL host_unexpected: got rvalid data %0h expected none (cycle %0d)", host_rdata, cyc);
            end else begin
                e = hq.pop_front();
                chk("host_latency", cyc, e.due);
                chk("host_data", host_rdata, e.data);
            end
        end
        if (hq.size() != 0 && hq[0].due < cyc) begin
            e = hq.pop_front();
            checks++; errors++;
            $display("FAIL host_missing: got no rvalid expected data %0h at cycle %0d", e.data, e.due);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one display fetch for the next edge; data comes back 3 cycles later.
    task automatic disp_push(input logic [AW-1:0] a, input logic [7:0] d);
        disp_req  = 1'b1;
        disp_addr = a;
        dq.push_back('{due: cyc + 3, data: d});
        tick();
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          exp_en;
        logic [7:0]    exp_data;
    } vec_t;
    vec_t tbl [12];

    initial begin
        tbl[0]  = '{12'd0,    1'b1, 8'h41};
        tbl[1]  = '{12'd1,    1'b1, 8'h42};
        tbl[2]  = '{12'd2,    1'b1, 8'h43};
        tbl[3]  = '{12'd3,    1'b1, 8'h44};
        tbl[4]  = '{12'd4,    1'b1, 8'h45};
        tbl[5]  = '{12'd5,    1'b1, 8'h46};
        tbl[6]  = '{12'd6,    1'b1, 8'h47};
        tbl[7]  = '{12'd7,    1'b1, 8'h48};
        tbl[8]  = '{12'd100,  1'b1, 8'h33};
        tbl[9]  = '{12'd2399, 1'b1, 8'hFA};
        tbl[10] = '{12'd2400, 1'b0, 8'h00};
        tbl[11] = '{12'd4095, 1'b0, 8'h00};

        for (int i = 0; i < 4096; i++) ram[i] = init_val(i);

        // Reset state
        repeat (3) tick();
        chk("rst_host_ready", host_ready, 1'b1);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_disp_rvalid", disp_rvalid, 1'b0);
        chk("rst_host_rvalid", host_rvalid, 1'b0);
        chk("rst_host_err", host_err, 1'b0);
        chk("rst_disp_rdata", disp_rdata, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back display fetches from the vector table
        for (int i = 0; i < 12; i++) begin
            disp_push(tbl[i].addr, tbl[i].exp_data);
            chk("tbl_mem_en", mem_en, tbl[i].exp_en);
            if (tbl[i].exp_en) chk("tbl_mem_addr", mem_addr, tbl[i].addr);
        end
        disp_req = 1'b0;
        repeat (6) tick();

        // Contention: host write held off by 10 display cycles
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                host_valid = 1'b1; host_we = 1'b1;
                host_addr = 12'd5; host_wdata = 8'h7E;
            end
            disp_push(12'(20 + i), init_val(20 + i));
            host_valid = 1'b0;
            chk("cont_mem_we", mem_we, 1'b0);
            if (i == 0) chk("cont_ready_low", host_ready, 1'b0);
        end
        disp_req = 1'b0;
        tick();
        chk("cont_issue_en", mem_en, 1'b1);
        chk("cont_issue_we", mem_we, 1'b1);
        chk("cont_issue_addr", mem_addr, 5);
        chk("cont_issue_wdata", mem_wdata, 8'h7E);
        chk("cont_ready_back", host_ready, 1'b1);
        tick();
        disp_push(12'd5, 8'h7E);
        disp_req = 1'b0;
        repeat (5) tick();

`ifdef TEXT_ARB_HOST_READ_EN
        // Host read, in range and out of range
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'd100;
        hq.push_back('{due: cyc + 4, data: 8'h33});
        tick();
        host_valid = 1'b0;
        tick();
        chk("hrd_mem_en", mem_en, 1'b1);
        chk("hrd_mem_we", mem_we, 1'b0);
        repeat (5) tick();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'd3000;
        hq.push_back('{due: cyc + 4, data: 8'h00});
        tick();
        host_valid = 1'b0;
        tick();
        chk("hrd_oor_err", host_err, 1'b1);
        chk("hrd_oor_en", mem_en, 1'b0);
        repeat (5) tick();
`else
        // Reads compiled out: a host_we=0 transaction becomes a write
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'd7; host_wdata = 8'h11;
        tick();
        host_valid = 1'b0;
        tick();
        chk("moff_mem_en", mem_en, 1'b1);
        chk("moff_mem_we", mem_we, 1'b1);
        chk("moff_mem_addr", mem_addr, 7);
        repeat (2) tick();
        chk("moff_ram7", ram[7], 8'h11);
        disp_push(12'd7, 8'h11);
        disp_req = 1'b0;
        repeat (5) tick();
        chk("moff_host_rdata", host_rdata, 0);
`endif

        // Out-of-range host write
        host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd2400; host_wdata = 8'h55;
        tick();
        host_valid = 1'b0;
        chk("oor_err_pre", host_err, 1'b0);
        tick();
        chk("oor_mem_en", mem_en, 1'b0);
        chk("oor_err_pulse", host_err, 1'b1);
        tick();
        chk("oor_err_clear", host_err, 1'b0);
        chk("oor_ready", host_ready, 1'b1);
        repeat (3) tick();

        // Reset mid-stream with reads and a held host write outstanding
        disp_push(12'd1, 8'h42);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd9; host_wdata = 8'hAA;
        disp_push(12'd2, 8'h43);
        host_valid = 1'b0;
        disp_req = 1'b0;
        rst_n = 1'b0;
        dq.delete();
        hq.delete();
        #1;
        chk("mid_rst_ready", host_ready, 1'b1);
        chk("mid_rst_mem_en", mem_en, 1'b0);
        chk("mid_rst_rvalid", disp_rvalid, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_mem_en", mem_en, 1'b0);
        end
        chk("post_rst_ram9", ram[9], init_val(9));

        chk("dq_empty", dq.size(), 0);
        chk("hq_empty", hq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
